clock_monitor: RTL

CLOCK_MONITOR -- requirements
Module: clock_monitor

---
 rtl/clock_monitor_pkg.sv | 15 +
 rtl/clock_monitor_channel.sv | 113 +++++++++++
 rtl/clock_monitor.sv | 70 +++++++
 3 files changed

// File: rtl/clock_monitor_pkg.sv
// rtl/clock_monitor_pkg.sv - shared state type and count width for the clock monitor
package clock_monitor_pkg;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_CHECK,
    ST_MONITOR,
    ST_FAULT
  } state_e;

endpackage

// File: rtl/clock_monitor_channel.sv
// rtl/clock_monitor_channel.sv - one monitored clock: synchronizer, half-period counter, FSM, status
module clock_monitor_channel
  import clock_monitor_pkg::*;
#(
  parameter int MIN     = 4,
  parameter int MAX     = 6,
  parameter int TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mon_clk_i,
  input  logic             enable_i,
  input  logic             clear_i,
  output logic             ok_o,
  output logic             fault_o,
  output logic             fault_set_o,
  output logic [CNT_W-1:0] period_o
);

  logic             sync1_q, sync2_q, sync3_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] period_q;
  state_e           state_q;
  logic             ok_q, fault_q, fault_set_q;

  logic             edge_det;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout;
  logic             in_range;

  assign edge_det = sync2_q ^ sync3_q;
  // Saturating increment doubles as the measured half-period on an edge cycle.
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign timeout  = (cnt_inc >= CNT_W'(TIMEOUT));
  assign in_range = (cnt_inc >= CNT_W'(MIN)) && (cnt_inc <= CNT_W'(MAX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      cnt_q       <= '0;
      period_q    <= '0;
      state_q     <= ST_IDLE;
      ok_q        <= 1'b0;
      fault_q     <= 1'b0;
      fault_set_q <= 1'b0;
    end else begin
      sync1_q     <= mon_clk_i;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      fault_set_q <= 1'b0;
      if (clear_i) fault_q <= 1'b0;

      if (!enable_i) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        ok_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            cnt_q   <= '0;
            state_q <= ST_ARM;
          end
          ST_ARM, ST_CHECK, ST_MONITOR: begin
            if (edge_det) begin
              cnt_q <= '0;
              if (state_q == ST_ARM) begin
                state_q <= ST_CHECK;
              end else begin
                period_q <= cnt_inc;
                if (in_range) begin
                  state_q <= ST_MONITOR;
                  ok_q    <= 1'b1;
                end else begin
                  state_q     <= ST_FAULT;
                  ok_q        <= 1'b0;
                  fault_q     <= 1'b1;
                  fault_set_q <= 1'b1;
                end
              end
            end else if (timeout) begin
              cnt_q       <= cnt_inc;
              state_q     <= ST_FAULT;
              ok_q        <= 1'b0;
              fault_q     <= 1'b1;
              fault_set_q <= 1'b1;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          ST_FAULT: begin
            if (clear_i) begin
              state_q <= ST_ARM;
              cnt_q   <= '0;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ok_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ok_o        = ok_q;
  assign fault_o     = fault_q;
  assign fault_set_o = fault_set_q;
  assign period_o    = period_q;

endmodule

// File: rtl/clock_monitor.sv
// rtl/clock_monitor.sv - dual clock monitor (lsi and wdt) with shared clear and fault interrupt
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int LSI_MIN = 4,
  parameter int LSI_MAX = 6,
  parameter int WDT_MIN = 9,
  parameter int WDT_MAX = 11,
  parameter int TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lsi_clk,
  input  logic             wdt_clk,
  input  logic             lsi_enable,
  input  logic             wdt_enable,
  input  logic             clear_status,
  output logic             lsi_ok,
  output logic             wdt_ok,
  output logic             lsi_fault,
  output logic             wdt_fault,
  output logic [CNT_W-1:0] lsi_period,
  output logic [CNT_W-1:0] wdt_period,
  output logic             fault_irq
);

  logic lsi_fault_set, wdt_fault_set;
  logic irq_q;

  clock_monitor_channel #(
    .MIN     (LSI_MIN),
    .MAX     (LSI_MAX),
    .TIMEOUT (TIMEOUT)
  ) u_lsi (
    .clk         (clk),
    .reset       (reset),
    .mon_clk_i   (lsi_clk),
    .enable_i    (lsi_enable),
    .clear_i     (clear_status),
    .ok_o        (lsi_ok),
    .fault_o     (lsi_fault),
    .fault_set_o (lsi_fault_set),
    .period_o    (lsi_period)
  );

  clock_monitor_channel #(
    .MIN     (WDT_MIN),
    .MAX     (WDT_MAX),
    .TIMEOUT (TIMEOUT)
  ) u_wdt (
    .clk         (clk),
    .reset       (reset),
    .mon_clk_i   (wdt_clk),
    .enable_i    (wdt_enable),
    .clear_i     (clear_status),
    .ok_o        (wdt_ok),
    .fault_o     (wdt_fault),
    .fault_set_o (wdt_fault_set),
    .period_o    (wdt_period)
  );

  // Simultaneous entries on both channels merge into one pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq_q <= 1'b0;
    else        irq_q <= lsi_fault_set | wdt_fault_set;
  end

  assign fault_irq = irq_q;

endmodule
